// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: op encodings, FSM states
// and iteration count.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        OpNop    = 3'b000,
        OpMult   = 3'b001,
        OpMultu  = 3'b010,
        OpDiv    = 3'b011,
        OpDivu   = 3'b100,
        OpMthi   = 3'b101,
        OpMtlo   = 3'b110,
        OpMfhilo = 3'b111
    } mdOp_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } mdState_e;

    localparam int unsigned MdIters = 32;

    function automatic logic isIterOp(input logic [2:0] op);
        return op inside {OpMult, OpMultu, OpDiv, OpDivu};
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage connection between the pipeline and the multiply-divide unit.
interface mult_div_unit_if;

    logic [2:0]  MdOpE;
    logic        MdSelHiE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        MdStallE;
    logic [31:0] HiLoOutE;
    logic        MdBusy;

    modport master (
        output MdOpE, MdSelHiE, SrcAE, SrcBE,
        input  MdStallE, HiLoOutE, MdBusy
    );

    modport slave (
        input  MdOpE, MdSelHiE, SrcAE, SrcBE,
        output MdStallE, HiLoOutE, MdBusy
    );

endinterface

// File: rtl/mdu_core.sv
// Iterative datapath: shift-add multiply / restoring divide on unsigned magnitudes,
// with sign correction of the final accumulator.
module mdu_core
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic [31:0] resHi,
    output logic [31:0] resLo
);

    logic [63:0] acc, accNext;
    logic [31:0] opnd;
    logic        signA, signB, isDiv;

    logic        loadSigned, loadDiv, negA, negB;
    logic [31:0] magA, magB;
    logic [32:0] mulSum;
    logic [33:0] divDiff;
    logic [63:0] prod;
    logic        negQuot;

    always_comb begin
        loadSigned = (op == OpMult) || (op == OpDiv);
        loadDiv    = (op == OpDiv) || (op == OpDivu);
        negA       = loadSigned && srcA[31];
        negB       = loadSigned && srcB[31];
        magA       = negA ? -srcA : srcA;
        magB       = negB ? -srcB : srcB;
    end

    // acc = {partial product, multiplier} for multiply, {remainder, quotient} for divide
    always_comb begin
        mulSum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        divDiff = {1'b0, acc[63:31]} - {2'b00, opnd};
        accNext = acc;
        if (isDiv) begin
            if (!divDiff[33]) accNext = {divDiff[31:0], acc[30:0], 1'b1};
            else              accNext = {acc[62:0], 1'b0};
        end else begin
            accNext = {mulSum, acc[31:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            opnd  <= '0;
            signA <= 1'b0;
            signB <= 1'b0;
            isDiv <= 1'b0;
        end else if (load) begin
            acc   <= {32'd0, loadDiv ? magA : magB};
            opnd  <= loadDiv ? magB : magA;
            signA <= negA;
            signB <= negB;
            isDiv <= loadDiv;
        end else if (step) begin
            acc <= accNext;
        end
    end

    // Zero divisor keeps the all-ones quotient; the remainder already equals the dividend.
    always_comb begin
        prod    = (signA ^ signB) ? -acc : acc;
        negQuot = (signA ^ signB) && (opnd != '0);
        if (isDiv) begin
            resLo = negQuot ? -acc[31:0] : acc[31:0];
            resHi = signA ? -acc[63:32] : acc[63:32];
        end else begin
            resLo = prod[31:0];
            resHi = prod[63:32];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: FSM, iteration counter, HI/LO registers and stall logic
// around the mdu_core datapath.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    mult_div_unit_if.slave  md
);

    mdState_e    state, stateNext;
    logic [5:0]  cnt;
    logic [31:0] hi, lo;
    logic [31:0] resHi, resLo;
    logic        accept, load, step;

    assign md.MdBusy   = (state != StIdle);
    assign md.MdStallE = md.MdBusy && (md.MdOpE != OpNop);
    assign md.HiLoOutE = (md.MdOpE == OpMfhilo) ? (md.MdSelHiE ? hi : lo) : '0;

    assign accept = (md.MdOpE != OpNop) && !md.MdStallE;
    assign load   = accept && isIterOp(md.MdOpE);
    assign step   = (state == StRun);

    mdu_core core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .op    (md.MdOpE),
        .srcA  (md.SrcAE),
        .srcB  (md.SrcBE),
        .resHi (resHi),
        .resLo (resLo)
    );

    always_comb begin
        stateNext = state;
        case (state)
            StIdle:  if (load) stateNext = StRun;
            StRun:   if (cnt == 6'(MdIters - 1)) stateNext = StFix;
            StFix:   stateNext = StIdle;
            default: stateNext = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= StIdle;
        else        state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            hi  <= '0;
            lo  <= '0;
        end else begin
            if (load)      cnt <= '0;
            else if (step) cnt <= cnt + 6'd1;

            if (state == StFix) begin
                hi <= resHi;
                lo <= resLo;
            end else if (accept) begin
                if (md.MdOpE == OpMthi) hi <= md.SrcAE;
                if (md.MdOpE == OpMtlo) lo <= md.SrcAE;
            end
        end
    end

endmodule
